csa_hybrid_adder32: RTL and testbench
=====================================

Name: csa_hybrid_adder32

Overview:
- Parameterised carry-select adder with a hybrid structure. It is built from BLOCK-bit carry-lookahead (CLA) sections, each computed twice (carry-in 0 and carry-in 1), with the real carry selecting between the two results.
- Outputs: sum, carry-out, and group propagate/generate for the whole word. This lets the block be chained as a CLA-style sub-adder.
- The result is registered once, behind a single clock and an asynchronous active-low reset.
- Used as a datapath adder and as an adder-architecture benchmark for switching-activity studies.

Parameters:
- N, 32, operand width in bits. Must be a multiple of BLOCK.
- BLOCK, 4, width of each CLA section. Each section is duplicated for carry-in 0 and carry-in 1.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cin  input  1  carry-in.
- a  input  N  operand A, unsigned.
- b  input  N  operand B, unsigned.
- s  output  N  registered sum bits, (a+b+cin)[N-1:0].
- cout  output  1  registered carry-out, (a+b+cin)[N].
- prop  output  1  registered group propagate, AND over i of (a[i]^b[i]).
- gen  output  1  registered group generate: carry-out of the word when cin=0.

Behaviour:
- Reset: while rst_n=0, s, cout, prop and gen are all 0. Assertion is asynchronous; release is sampled on the next rising clk.
- Latency is one cycle. The result for the inputs present before rising edge k appears on the outputs after edge k and holds until edge k+1.
- There is no handshake. A new operation is accepted every cycle.
- Bit level, per bit i: p[i]=a[i]^b[i], g[i]=a[i]&b[i].
- Section level, for each BLOCK-bit section j:
  - Compute the CLA carries internally for carry-in 0 and for carry-in 1.
  - Produce sum0/sum1 and section carry-outs c0/c1.
  - Produce section propagate P_j = AND of p, and section generate G_j = c0.
- Section 0 uses cin directly; no duplication is needed.
- Selection chain: for section j>0, the selected carry C_j picks sum1/c1 when C_j=1, otherwise sum0/c0. C_{j+1} = selected carry-out.
- Word level:
  - prop = AND of all P_j.
  - gen = ripple of G/P across sections with carry-in 0.
  - cout = gen | (prop & cin).
- Invariant: {cout,s} equals a+b+cin modulo 2^(N+1), exactly. This is an exact adder, not an approximate one.
- Boundary cases:
  - All-ones plus zero with cin=1 wraps: s=0, cout=1, prop=1, gen=0.
  - a=b=all-ones: gen=1, prop=0.
- Reset asserted mid-stream clears the outputs immediately. The first valid result after release appears one cycle after the first sampled edge.
- X-free: all outputs are driven from flops with a defined reset.

Optional Feature:
- Macro: CSA_INPUT_REG_EN.
- Defined:
  - a, b and cin are additionally registered (reset to 0) before the adder logic.
  - Total latency becomes 2 cycles.
  - Outputs stay 0 for 2 edges after reset release, because the reset inputs give 0+0+0=0, prop=0, gen=0.
- Undefined: combinational adder feeding the output register only; latency 1.

Test Plan:
- Reset: hold rst_n=0 with a=32'hFFFFFFFF, b=1, cin=1 -> s=0, cout=0, prop=0, gen=0 throughout. Deassert -> after one edge s=32'h00000001, cout=1.
- Simple add: a=32'h00000005, b=32'h00000003, cin=0 -> s=32'h00000008, cout=0, prop=0, gen=0, one cycle later.
- Full propagate: a=32'hFFFFFFFF, b=0, cin=1 -> s=0, cout=1, prop=1, gen=0. Same operands with cin=0 -> s=32'hFFFFFFFF, cout=0, prop=1.
- Full generate: a=b=32'hFFFFFFFF, cin=0 -> s=32'hFFFFFFFE, cout=1, prop=0, gen=1.
- Section-boundary carries: a=32'h0000000F, b=1, cin=0 -> s=32'h00000010. Also a=32'h0FFFFFFF, b=1 -> s=32'h10000000, cout=0.
- Random back-to-back: 30000 random a, b, cin, one per cycle -> every output equals the reference sum a+b+cin delayed by one cycle (two with CSA_INPUT_REG_EN), with prop/gen matching the definitions above. Assert rst_n low mid-run -> outputs go to 0 immediately.

Source files
------------

// File: rtl/csa_hybrid_adder32.sv
// Hybrid carry-select adder: duplicated CLA sections, carry-selected, one output register.
// Define CSA_INPUT_REG_EN to also register a, b and cin (latency 2).
module csa_hybrid_adder32 #(
    parameter int N     = 32,
    parameter int BLOCK = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cin,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] s,
    output logic         cout,
    output logic         prop,
    output logic         gen
);

    localparam int NS = N / BLOCK;

    logic [N-1:0] a_x;
    logic [N-1:0] b_x;
    logic         cin_x;

`ifdef CSA_INPUT_REG_EN
    logic [N-1:0] a_q;
    logic [N-1:0] b_q;
    logic         cin_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            cin_q <= 1'b0;
        end else begin
            a_q   <= a;
            b_q   <= b;
            cin_q <= cin;
        end
    end

    assign a_x   = a_q;
    assign b_x   = b_q;
    assign cin_x = cin_q;
`else
    assign a_x   = a;
    assign b_x   = b;
    assign cin_x = cin;
`endif

    logic [N-1:0]  p;
    logic [N-1:0]  g;
    logic [N-1:0]  sum0;
    logic [N-1:0]  sum1;
    logic [NS-1:0] c0;
    logic [NS-1:0] c1;
    logic [NS-1:0] sp;

    assign p = a_x ^ b_x;
    assign g = a_x & b_x;

    // Each section: prefix G/P over its bits gives carries for cin=0 (gp) and cin=1 (gp|pp)
    for (genvar j = 0; j < NS; j++) begin : g_sec
        logic [BLOCK-1:0] pb;
        logic [BLOCK-1:0] gb;
        logic [BLOCK:0]   gp;
        logic [BLOCK:0]   pp;

        assign pb = p[j*BLOCK +: BLOCK];
        assign gb = g[j*BLOCK +: BLOCK];

        always_comb begin
            gp[0] = 1'b0;
            pp[0] = 1'b1;
            for (int k = 0; k < BLOCK; k++) begin
                gp[k+1] = gb[k] | (pb[k] & gp[k]);
                pp[k+1] = pb[k] & pp[k];
            end
        end

        assign sum0[j*BLOCK +: BLOCK] = pb ^ gp[BLOCK-1:0];
        assign sum1[j*BLOCK +: BLOCK] = pb ^ (gp[BLOCK-1:0] | pp[BLOCK-1:0]);
        assign c0[j] = gp[BLOCK];
        assign c1[j] = gp[BLOCK] | pp[BLOCK];
        assign sp[j] = pp[BLOCK];
    end

    logic [N-1:0] s_d;
    logic         cout_d;
    logic         prop_d;
    logic         gen_d;
    logic         csel;

    always_comb begin
        s_d  = '0;
        csel = cin_x;
        for (int j = 0; j < NS; j++) begin
            s_d[j*BLOCK +: BLOCK] = csel ? sum1[j*BLOCK +: BLOCK]
                                         : sum0[j*BLOCK +: BLOCK];
            csel = csel ? c1[j] : c0[j];
        end
    end

    always_comb begin
        gen_d  = 1'b0;
        prop_d = 1'b1;
        for (int j = 0; j < NS; j++) begin
            gen_d  = c0[j] | (sp[j] & gen_d);
            prop_d = prop_d & sp[j];
        end
        cout_d = gen_d | (prop_d & cin_x);
    end

    logic [N-1:0] s_q;
    logic         cout_q;
    logic         prop_q;
    logic         gen_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q    <= '0;
            cout_q <= 1'b0;
            prop_q <= 1'b0;
            gen_q  <= 1'b0;
        end else begin
            s_q    <= s_d;
            cout_q <= cout_d;
            prop_q <= prop_d;
            gen_q  <= gen_d;
        end
    end

    assign s    = s_q;
    assign cout = cout_q;
    assign prop = prop_q;
    assign gen  = gen_q;

endmodule

// File: tb/tb_csa_hybrid_adder32.sv
// Bench for csa_hybrid_adder32: arithmetic reference model plus directed literal vectors.
module tb_csa_hybrid_adder32;

`ifdef CSA_INPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cin = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [31:0] s;
    logic        cout;
    logic        prop;
    logic        gen;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    csa_hybrid_adder32 #(.N(32), .BLOCK(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .cin  (cin),
        .a    (a),
        .b    (b),
        .s    (s),
        .cout (cout),
        .prop (prop),
        .gen  (gen)
    );

    always #5 clk = ~clk;

    // {s, cout, prop, gen} from plain arithmetic
    function automatic logic [34:0] ref_of(input logic [31:0] x,
                                           input logic [31:0] y,
                                           input logic ci);
        logic [32:0] full;
        logic [32:0] nocin;
        full  = {1'b0, x} + {1'b0, y} + {32'd0, ci};
        nocin = {1'b0, x} + {1'b0, y};
        return {full[31:0], full[32], &(x ^ y), nocin[32]};
    endfunction

    logic [31:0] ha [LAT];
    logic [31:0] hb [LAT];
    logic        hc [LAT];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                ha[i] <= '0;
                hb[i] <= '0;
                hc[i] <= 1'b0;
            end
        end else begin
            ha[0] <= a;
            hb[0] <= b;
            hc[0] <= cin;
            for (int i = 1; i < LAT; i++) begin
                ha[i] <= ha[i-1];
                hb[i] <= hb[i-1];
                hc[i] <= hc[i-1];
            end
        end
    end

    task automatic chk(input string name, input logic [34:0] act,
                       input logic [34:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got={s,cout,prop,gen}=%h expected=%h at %0t",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en)
            chk("model", {s, cout, prop, gen},
                ref_of(ha[LAT-1], hb[LAT-1], hc[LAT-1]));
    end

    task automatic vec(input string name, input logic [31:0] x,
                       input logic [31:0] y, input logic ci,
                       input logic [31:0] es, input logic ec,
                       input logic ep, input logic eg);
        @(negedge clk);
        a   = x;
        b   = y;
        cin = ci;
        repeat (LAT) @(posedge clk);
        #1;
        chk(name, {s, cout, prop, gen}, {es, ec, ep, eg});
    endtask

    initial begin
        #1;
        a     = 32'hFFFFFFFF;
        b     = 32'h00000001;
        cin   = 1'b1;
        rst_n = 1'b0;
        #1;
        cmp_en = 1'b1;
        chk("reset_async", {s, cout, prop, gen}, 35'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_hold", {s, cout, prop, gen}, 35'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (LAT) @(posedge clk);
        #1;
        chk("reset_release", {s, cout, prop, gen},
            {32'h00000001, 1'b1, 1'b0, 1'b1});

        vec("simple",    32'h00000005, 32'h00000003, 1'b0,
            32'h00000008, 1'b0, 1'b0, 1'b0);
        vec("prop_cin1", 32'hFFFFFFFF, 32'h00000000, 1'b1,
            32'h00000000, 1'b1, 1'b1, 1'b0);
        vec("prop_cin0", 32'hFFFFFFFF, 32'h00000000, 1'b0,
            32'hFFFFFFFF, 1'b0, 1'b1, 1'b0);
        vec("gen_all",   32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0,
            32'hFFFFFFFE, 1'b1, 1'b0, 1'b1);
        vec("gen_cin1",  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1,
            32'hFFFFFFFF, 1'b1, 1'b0, 1'b1);
        vec("sec0_carry", 32'h0000000F, 32'h00000001, 1'b0,
            32'h00000010, 1'b0, 1'b0, 1'b0);
        vec("sec6_carry", 32'h0FFFFFFF, 32'h00000001, 1'b0,
            32'h10000000, 1'b0, 1'b0, 1'b0);
        vec("alt_prop",  32'hAAAAAAAA, 32'h55555555, 1'b1,
            32'h00000000, 1'b1, 1'b1, 1'b0);
        vec("mid_sec",   32'h00F0F000, 32'h00101000, 1'b1,
            32'h01010001, 1'b0, 1'b0, 1'b0);

        for (int n = 0; n < 30000; n++) begin
            @(negedge clk);
            a   = $urandom;
            b   = $urandom;
            cin = 1'($urandom_range(0, 1));
            if (n == 15000) begin
                rst_n = 1'b0;
                #1;
                chk("reset_midrun", {s, cout, prop, gen}, 35'd0);
            end
            if (n == 15002)
                rst_n = 1'b1;
        end

        repeat (LAT + 1) @(posedge clk);
        @(negedge clk);
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
